// File: rtl/shift_seq_ctrl.sv
// Sequencing controller for the triplicated universal shift register: runs complete
// LSB-first TX and RX frames behind valid/ready handshakes.
module shift_seq_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_bit_valid,
  input  logic             rx_start,
  output logic             rx_bit_req,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [WIDTH-1:0] rx_data,
  input  logic             abort,
  output logic             busy,
  output logic [1:0]       reg_mode,
  output logic             reg_load,
  output logic             reg_enable,
  output logic [WIDTH-1:0] reg_parallel_in,
  input  logic [WIDTH-1:0] reg_parallel_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX_LOAD,
    S_TX_SHIFT,
    S_RX_SHIFT,
    S_RX_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [WIDTH-1:0] par_in_q;
  logic             tx_accept;

  assign tx_accept       = (state == S_IDLE) && tx_valid && !abort;
  assign reg_parallel_in = par_in_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      par_in_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (tx_accept) par_in_q <= tx_data;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (abort) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          // tx_valid wins a same-cycle rx_start; the rx request is simply dropped
          if (tx_valid) begin
            state_nxt = S_TX_LOAD;
          end else if (rx_start) begin
            state_nxt = S_RX_SHIFT;
            cnt_nxt   = '0;
          end
        end
        S_TX_LOAD: begin
          state_nxt = S_TX_SHIFT;
          cnt_nxt   = '0;
        end
        S_TX_SHIFT: begin
          if (cnt == CNT_LAST) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        S_RX_SHIFT: begin
          if (cnt == CNT_LAST) begin
            state_nxt = S_RX_DONE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        S_RX_DONE: begin
          if (rx_ready) state_nxt = S_IDLE;
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs decode from state only; rx_data is gated so it reads zero outside RX_DONE
  always_comb begin
    tx_ready     = 1'b0;
    tx_bit_valid = 1'b0;
    rx_bit_req   = 1'b0;
    rx_valid     = 1'b0;
    rx_data      = '0;
    busy         = (state != S_IDLE);
    reg_mode     = 2'b11;
    reg_load     = 1'b0;
    reg_enable   = 1'b0;
    unique case (state)
      S_IDLE: tx_ready = 1'b1;
      S_TX_LOAD: begin
        reg_mode   = 2'b10;
        reg_load   = 1'b1;
        reg_enable = 1'b1;
      end
      S_TX_SHIFT: begin
        reg_mode     = 2'b10;
        reg_enable   = 1'b1;
        tx_bit_valid = 1'b1;
      end
      S_RX_SHIFT: begin
        reg_mode   = 2'b00;
        reg_enable = 1'b1;
        rx_bit_req = 1'b1;
      end
      S_RX_DONE: begin
        rx_valid = 1'b1;
        rx_data  = reg_parallel_out;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: a frame-level model (cycles since request) plus a simple
// shift-register model closing the loop through reg_parallel_out.
module tb_shift_seq_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         tx_valid = 1'b0;
  logic         tx_ready;
  logic [W-1:0] tx_data = '0;
  logic         tx_bit_valid;
  logic         rx_start = 1'b0;
  logic         rx_bit_req;
  logic         rx_valid;
  logic         rx_ready = 1'b0;
  logic [W-1:0] rx_data;
  logic         abort = 1'b0;
  logic         busy;
  logic [1:0]   reg_mode;
  logic         reg_load;
  logic         reg_enable;
  logic [W-1:0] reg_parallel_in;
  logic [W-1:0] reg_parallel_out;
  logic         serial_in = 1'b0;
  logic         serial_out;

  int n_total = 0;
  int n_pass  = 0;

  shift_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_bit_valid(tx_bit_valid),
    .rx_start(rx_start), .rx_bit_req(rx_bit_req),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .abort(abort), .busy(busy),
    .reg_mode(reg_mode), .reg_load(reg_load), .reg_enable(reg_enable),
    .reg_parallel_in(reg_parallel_in), .reg_parallel_out(reg_parallel_out)
  );

  always #5 clk = ~clk;

  // Universal shift register: 10 shifts right (LSB out), 00 shifts right with serial_in at MSB
  logic [W-1:0] sreg = '0;
  always @(posedge clk) begin
    if (reg_enable) begin
      if (reg_load) sreg <= reg_parallel_in;
      else if (reg_mode == 2'b10) sreg <= {1'b0, sreg[W-1:1]};
      else if (reg_mode == 2'b00) sreg <= {serial_in, sreg[W-1:1]};
    end
  end
  assign reg_parallel_out = sreg;
  assign serial_out       = sreg[0];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Frame model: kind 0 none, 1 tx, 2 rx; age = cycles since the accepting edge
  int           m_kind = 0;
  int           m_age  = 0;
  logic [W-1:0] m_word = '0;
  logic [W-1:0] m_hold = '0;
  logic [W-1:0] m_rx   = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_kind <= 0; m_age <= 0; m_hold <= '0;
    end else if (abort) begin
      m_kind <= 0; m_age <= 0;
    end else begin
      case (m_kind)
        0: begin
          if (tx_valid) begin
            m_kind <= 1; m_age <= 1; m_word <= tx_data; m_hold <= tx_data;
          end else if (rx_start) begin
            m_kind <= 2; m_age <= 1; m_rx <= '0;
          end
        end
        1: begin
          if (m_age == W + 1) begin m_kind <= 0; m_age <= 0; end
          else m_age <= m_age + 1;
        end
        default: begin
          if (m_age <= W) begin
            m_rx[m_age-1] <= serial_in;
            m_age <= m_age + 1;
          end else if (rx_ready) begin
            m_kind <= 0; m_age <= 0;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    logic e_tx, e_ld, e_tbv, e_rxs, e_rxv;
    logic [1:0] e_mode;
    e_tx   = (m_kind == 1);
    e_ld   = e_tx && (m_age == 1);
    e_tbv  = e_tx && (m_age >= 2);
    e_rxs  = (m_kind == 2) && (m_age <= W);
    e_rxv  = (m_kind == 2) && (m_age > W);
    e_mode = e_tx ? 2'b10 : (e_rxs ? 2'b00 : 2'b11);
    check("tx_ready",     64'(tx_ready),     64'(m_kind == 0));
    check("busy",         64'(busy),         64'(m_kind != 0));
    check("reg_mode",     64'(reg_mode),     64'(e_mode));
    check("reg_load",     64'(reg_load),     64'(e_ld));
    check("reg_enable",   64'(reg_enable),   64'(e_tx || e_rxs));
    check("tx_bit_valid", 64'(tx_bit_valid), 64'(e_tbv));
    check("rx_bit_req",   64'(rx_bit_req),   64'(e_rxs));
    check("rx_valid",     64'(rx_valid),     64'(e_rxv));
    check("rx_data",      64'(rx_data),      64'(e_rxv ? m_rx : '0));
    check("reg_parallel_in", 64'(reg_parallel_in), 64'(m_hold));
    if (e_tbv) check("serial_out", 64'(serial_out), 64'(m_word[m_age-2]));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tx(input logic [W-1:0] w, input logic with_rx,
                       output logic [W-1:0] got, output int nvalid, output int nreq);
    tx_valid = 1'b1; tx_data = w; rx_start = with_rx;
    step();
    tx_valid = 1'b0; tx_data = ~w; rx_start = with_rx;
    step();
    rx_start = 1'b0;
    got = '0; nvalid = 0; nreq = 0;
    for (int k = 0; k < W; k++) begin
      got[k] = serial_out;
      if (tx_bit_valid) nvalid++;
      if (rx_bit_req) nreq++;
      step();
    end
    check("tx_ready_after_frame", 64'(tx_ready), 64'(1));
    check("tbv_after_frame", 64'(tx_bit_valid), 64'(0));
  endtask

  task automatic do_rx(input logic [W-1:0] w);
    rx_start = 1'b1;
    step();
    rx_start = 1'b0;
    for (int k = 0; k < W; k++) begin
      serial_in = w[k];
      if (k == W - 1) check("rx_valid_before_done", 64'(rx_valid), 64'(0));
      step();
    end
    serial_in = 1'b1;
    check("rx_valid_rise", 64'(rx_valid), 64'(1));
    check("rx_data_word", 64'(rx_data), 64'(w));
    for (int i = 0; i < 5; i++) begin
      step();
      check("rx_data_hold", 64'(rx_data), 64'(w));
      check("rx_valid_hold", 64'(rx_valid), 64'(1));
    end
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    check("rx_valid_after_ready", 64'(rx_valid), 64'(0));
    check("busy_after_ready", 64'(busy), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] got;
    int nv, nr;

    // Reset with random inputs
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tx_valid = 1'($urandom); rx_start = 1'($urandom); rx_ready = 1'($urandom);
      abort = 1'($urandom); tx_data = $urandom; serial_in = 1'($urandom);
      step();
    end
    check("rst_tx_ready", 64'(tx_ready), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_reg_mode", 64'(reg_mode), 64'(2'b11));
    check("rst_reg_enable", 64'(reg_enable), 64'(0));
    check("rst_par_in", 64'(reg_parallel_in), 64'(0));
    check("rst_rx_data", 64'(rx_data), 64'(0));
    tx_valid = 1'b0; rx_start = 1'b0; rx_ready = 1'b0; abort = 1'b0; tx_data = '0;
    rst = 1'b1;
    step();

    // TX A5A5_0F0F
    do_tx(32'hA5A5_0F0F, 1'b0, got, nv, nr);
    check("tx_first_bits", 64'(got[7:0]), 64'(8'h0F));
    check("tx_word", 64'(got), 64'(32'hA5A5_0F0F));
    check("tx_bit_valid_count", 64'(nv), 64'(32));
    step();

    // RX DEAD_BEEF
    do_rx(32'hDEAD_BEEF);
    step();

    // Simultaneous tx_valid + rx_start: TX runs, RX dropped
    do_tx(32'h8000_0001, 1'b1, got, nv, nr);
    check("simul_tx_word", 64'(got), 64'(32'h8000_0001));
    check("simul_rx_req_count", 64'(nr), 64'(0));
    for (int i = 0; i < 3; i++) begin
      step();
      check("simul_no_rx_queued", 64'(rx_bit_req), 64'(0));
    end

    // Abort at TX_SHIFT counter 10 (cycle 12)
    tx_valid = 1'b1; tx_data = 32'hFFFF_FFFF;
    step();
    tx_valid = 1'b0;
    for (int i = 0; i < 11; i++) step();
    check("abort_pre_tbv", 64'(tx_bit_valid), 64'(1));
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_tbv", 64'(tx_bit_valid), 64'(0));
    check("abort_enable", 64'(reg_enable), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    do_tx(32'h0000_0001, 1'b0, got, nv, nr);
    check("post_abort_word", 64'(got), 64'(32'h0000_0001));
    check("post_abort_count", 64'(nv), 64'(32));
    step();

    // Reset mid-RX at counter 20 (cycle 21)
    rx_start = 1'b1;
    step();
    rx_start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      serial_in = 1'($urandom);
      step();
    end
    check("pre_rst_rx_req", 64'(rx_bit_req), 64'(1));
    #2 rst = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_rx_req", 64'(rx_bit_req), 64'(0));
    check("mid_rst_enable", 64'(reg_enable), 64'(0));
    check("mid_rst_mode", 64'(reg_mode), 64'(2'b11));
    check("mid_rst_tx_ready", 64'(tx_ready), 64'(1));
    step();
    rst = 1'b1;
    step();
    do_rx(32'h1234_5678);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
